// File: rtl/multiplier_pipe_mac.sv
// Pipelined signed/unsigned multiplier with valid/tag pipeline and a
// multiply-accumulate back end with clear and sticky wrap detection.
module multiplier_pipe_mac #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGES    = 3,
  parameter int unsigned ACC_WIDTH = 2 * WIDTH + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   signed_mode,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  output logic                   out_valid,
  output logic [2*WIDTH-1:0]     y,
  output logic                   acc_valid,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   acc_ovf
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned AMSB = ACC_WIDTH - 1;

  logic [STAGES-1:0]    vld_q, vld_d;
  logic [STAGES-1:0]    sgn_q, sgn_d;
  logic [STAGES-1:0]    en_q, en_d;
  logic [STAGES-1:0]    clr_q, clr_d;
  logic [PW-1:0]        prod_q [STAGES];
  logic [PW-1:0]        prod_d [STAGES];

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 acc_valid_q, acc_valid_d;
  logic                 acc_ovf_q, acc_ovf_d;

  logic [PW-1:0]        a_ext, b_ext, mult;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 wrap;

  // Operands extended to full product width so one multiplier serves both modes.
  always_comb begin
    a_ext = signed_mode ? PW'($signed(a)) : PW'(a);
    b_ext = signed_mode ? PW'($signed(b)) : PW'(b);
    mult  = a_ext * b_ext;
  end

  // Valid bits always advance; data and tags load only behind a valid slot.
  always_comb begin
    vld_d[0]  = in_valid;
    sgn_d[0]  = in_valid ? signed_mode : sgn_q[0];
    en_d[0]   = in_valid ? acc_en      : en_q[0];
    clr_d[0]  = in_valid ? acc_clr     : clr_q[0];
    prod_d[0] = in_valid ? mult        : prod_q[0];
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i]  = vld_q[i-1];
      sgn_d[i]  = vld_q[i-1] ? sgn_q[i-1]  : sgn_q[i];
      en_d[i]   = vld_q[i-1] ? en_q[i-1]   : en_q[i];
      clr_d[i]  = vld_q[i-1] ? clr_q[i-1]  : clr_q[i];
      prod_d[i] = vld_q[i-1] ? prod_q[i-1] : prod_q[i];
    end
  end

  // Accumulator consumes the product in the cycle it is presented on y.
  always_comb begin
    acc_d       = acc_q;
    acc_valid_d = 1'b0;
    acc_ovf_d   = acc_ovf_q;
    p_ext       = sgn_q[LAST] ? ACC_WIDTH'($signed(prod_q[LAST]))
                              : ACC_WIDTH'(prod_q[LAST]);
    sum         = {1'b0, acc_q} + {1'b0, p_ext};
    wrap        = sgn_q[LAST] ? ((acc_q[AMSB] == p_ext[AMSB]) && (sum[AMSB] != acc_q[AMSB]))
                              : sum[ACC_WIDTH];
    if (vld_q[LAST]) begin
      if (clr_q[LAST]) begin
        acc_d       = en_q[LAST] ? p_ext : '0;
        acc_ovf_d   = 1'b0;
        acc_valid_d = 1'b1;
      end else if (en_q[LAST]) begin
        acc_d       = sum[ACC_WIDTH-1:0];
        acc_ovf_d   = acc_ovf_q | wrap;
        acc_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      sgn_q       <= '0;
      en_q        <= '0;
      clr_q       <= '0;
      for (int i = 0; i < STAGES; i++) prod_q[i] <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      sgn_q       <= sgn_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      for (int i = 0; i < STAGES; i++) prod_q[i] <= prod_d[i];
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign out_valid = vld_q[LAST];
  assign y         = prod_q[LAST];
  assign acc_valid = acc_valid_q;
  assign acc       = acc_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_multiplier_pipe_mac.sv
// Scoreboard bench: three instances (STAGES 3/1/2, ACC_WIDTH 24/24/16) share
// one stimulus stream; expected products and accumulator states are queued at issue.
module tb_multiplier_pipe_mac;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, signed_mode, acc_en, acc_clr;
  logic [7:0] a, b;

  logic        ov0, ov1, ov2, av0, av1, av2, of0, of1, of2;
  logic [15:0] y0, y1, y2;
  logic [23:0] acc0, acc1;
  logic [15:0] acc2;

  logic        ov_a [3];
  logic        av_a [3];
  logic        of_a [3];
  logic [15:0] y_a  [3];
  logic [23:0] acc_a[3];

  always #5 clk = ~clk;

  multiplier_pipe_mac #(.WIDTH(8), .STAGES(3), .ACC_WIDTH(24)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .signed_mode(signed_mode),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov0), .y(y0), .acc_valid(av0),
    .acc(acc0), .acc_ovf(of0));
  multiplier_pipe_mac #(.WIDTH(8), .STAGES(1), .ACC_WIDTH(24)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .signed_mode(signed_mode),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov1), .y(y1), .acc_valid(av1),
    .acc(acc1), .acc_ovf(of1));
  multiplier_pipe_mac #(.WIDTH(8), .STAGES(2), .ACC_WIDTH(16)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .signed_mode(signed_mode),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov2), .y(y2), .acc_valid(av2),
    .acc(acc2), .acc_ovf(of2));

  assign ov_a[0] = ov0;  assign ov_a[1] = ov1;  assign ov_a[2] = ov2;
  assign av_a[0] = av0;  assign av_a[1] = av1;  assign av_a[2] = av2;
  assign of_a[0] = of0;  assign of_a[1] = of1;  assign of_a[2] = of2;
  assign y_a[0]  = y0;   assign y_a[1]  = y1;   assign y_a[2]  = y2;
  assign acc_a[0] = acc0; assign acc_a[1] = acc1; assign acc_a[2] = {8'd0, acc2};

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [15:0] y;   logic [31:0] due; } yexp_t;
  typedef struct packed { logic [23:0] acc; logic ovf; logic [31:0] due; } aexp_t;

  yexp_t       yq[3][$];
  aexp_t       aq[3][$];
  logic [23:0] m_acc[3];
  logic        m_ovf[3];
  logic [15:0] last_y[3];
  logic [23:0] last_acc[3];
  logic        last_ovf[3];
  int          n_iss[3];
  int          n_out[3];

  function automatic int unsigned stg(input int k);
    return (k == 0) ? 3 : (k == 1) ? 1 : 2;
  endfunction

  function automatic int unsigned aw(input int k);
    return (k == 2) ? 16 : 24;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      yq[k].delete();
      aq[k].delete();
      m_acc[k] = '0; m_ovf[k] = 1'b0;
      last_y[k] = '0; last_acc[k] = '0; last_ovf[k] = 1'b0;
      n_iss[k] = 0; n_out[k] = 0;
    end
  endtask

  // Drive one slot at the falling edge and queue what each instance must produce.
  task automatic issue(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic s, input logic en, input logic clr);
    logic [15:0] py;
    logic [63:0] mask, p, sum, r;
    logic        cry, sov;
    int unsigned w;
    @(negedge clk);
    in_valid = v; a = ia; b = ib; signed_mode = s; acc_en = en; acc_clr = clr;
    if (v) begin
      py = 16'(s ? (int'($signed(ia)) * int'($signed(ib))) : (int'(ia) * int'(ib)));
      for (int k = 0; k < 3; k++) begin
        yq[k].push_back('{y: py, due: 32'(cyc) + 32'(stg(k))});
        n_iss[k]++;
        if (en || clr) begin
          w    = aw(k);
          mask = (64'd1 << w) - 64'd1;
          p    = (s ? {{48{py[15]}}, py} : {48'd0, py}) & mask;
          if (en && !clr) begin
            sum = 64'(m_acc[k]) + p;
            r   = sum & mask;
            cry = sum[w];
            sov = (m_acc[k][w-1] == p[w-1]) && (r[w-1] != m_acc[k][w-1]);
            m_acc[k] = 24'(r);
            if (s ? sov : cry) m_ovf[k] = 1'b1;
          end else begin
            m_acc[k] = en ? 24'(p) : 24'd0;
            m_ovf[k] = 1'b0;
          end
          aq[k].push_back('{acc: m_acc[k], ovf: m_ovf[k], due: 32'(cyc) + 32'(stg(k)) + 32'd1});
        end
      end
    end
  endtask

  // Idle until every queue has been consumed, bounded.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      done = 1'b1;
      for (int k = 0; k < 3; k++)
        if (yq[k].size() != 0 || aq[k].size() != 0) done = 1'b0;
    end
    check_eq("drain_complete", 64'(done), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        yexp_t ye;
        aexp_t ae;
        if (ov_a[k]) begin
          n_out[k]++;
          check_eq($sformatf("d%0d_out_valid_expected", k), 64'(yq[k].size() > 0), 64'd1);
          if (yq[k].size() > 0) begin
            ye = yq[k].pop_front();
            check_eq($sformatf("d%0d_y", k), 64'(y_a[k]), 64'(ye.y));
            check_eq($sformatf("d%0d_y_latency", k), 64'(cyc), 64'(ye.due));
            last_y[k] = ye.y;
          end
        end else begin
          check_eq($sformatf("d%0d_y_hold", k), 64'(y_a[k]), 64'(last_y[k]));
        end
        if (av_a[k]) begin
          check_eq($sformatf("d%0d_acc_valid_expected", k), 64'(aq[k].size() > 0), 64'd1);
          if (aq[k].size() > 0) begin
            ae = aq[k].pop_front();
            check_eq($sformatf("d%0d_acc", k), 64'(acc_a[k]), 64'(ae.acc));
            check_eq($sformatf("d%0d_acc_ovf", k), 64'(of_a[k]), 64'(ae.ovf));
            check_eq($sformatf("d%0d_acc_latency", k), 64'(cyc), 64'(ae.due));
            last_acc[k] = ae.acc;
            last_ovf[k] = ae.ovf;
          end
        end else begin
          check_eq($sformatf("d%0d_acc_hold", k), 64'(acc_a[k]), 64'(last_acc[k]));
          check_eq($sformatf("d%0d_ovf_hold", k), 64'(of_a[k]), 64'(last_ovf[k]));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_d%0d_out_valid", tag, k), 64'(ov_a[k]), 64'd0);
      check_eq($sformatf("%s_d%0d_y", tag, k), 64'(y_a[k]), 64'd0);
      check_eq($sformatf("%s_d%0d_acc_valid", tag, k), 64'(av_a[k]), 64'd0);
      check_eq($sformatf("%s_d%0d_acc", tag, k), 64'(acc_a[k]), 64'd0);
      check_eq($sformatf("%s_d%0d_acc_ovf", tag, k), 64'(of_a[k]), 64'd0);
    end
  endtask

  logic [31:0] xs;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    xs = 32'h1234_5678;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Latency: 12*10 unsigned
    issue(1'b1, 8'd12, 8'd10, 1'b0, 1'b0, 1'b0);
    drain();
    check_eq("lat_y_stages3", 64'(y0), 64'd120);
    check_eq("lat_y_stages1", 64'(y1), 64'd120);

    // Mode toggle back-to-back, then signed -128*-128
    issue(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    drain();
    check_eq("signed_min_sq", 64'(y0), 64'h4000);

    // Accumulate 12, 42, 98 then signed -6 -> 92
    issue(1'b1, 8'd3, 8'd4, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 8'd5, 8'd6, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 8'd7, 8'd8, 1'b0, 1'b1, 1'b0);
    drain();
    check_eq("acc_98", 64'(acc0), 64'd98);
    check_eq("acc_98_ovf", 64'(of0), 64'd0);
    issue(1'b1, 8'hFE, 8'd3, 1'b1, 1'b1, 1'b0);
    drain();
    check_eq("acc_92", 64'(acc0), 64'd92);
    check_eq("acc_92_w16", 64'(acc2), 64'd92);

    // Unsigned wrap in the 16-bit accumulator, then clear via a clr op
    issue(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    drain();
    check_eq("ovf_acc_w16", 64'(acc2), 64'hFC02);
    check_eq("ovf_flag_w16", 64'(of2), 64'd1);
    check_eq("no_ovf_w24", 64'(of0), 64'd0);
    issue(1'b1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
    drain();
    check_eq("clr_acc_w16", 64'(acc2), 64'd1);
    check_eq("clr_ovf_w16", 64'(of2), 64'd0);

    // Signed wrap: 0x4000 + 0x4000 in 16 bits, then clear-only op
    issue(1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 1'b1);
    issue(1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    drain();
    check_eq("sovf_acc_w16", 64'(acc2), 64'h8000);
    check_eq("sovf_flag_w16", 64'(of2), 64'd1);
    issue(1'b1, 8'd9, 8'd9, 1'b0, 1'b0, 1'b1);
    drain();
    check_eq("clr_only_acc", 64'(acc2), 64'd0);
    check_eq("clr_only_ovf", 64'(of2), 64'd0);

    // Random stream with gaps, random mode and accumulate controls
    for (int i = 0; i < 20; i++) begin
      xs = xs ^ (xs << 13); xs = xs ^ (xs >> 17); xs = xs ^ (xs << 5);
      if (xs[31:30] == 2'b00) issue(1'b0, xs[7:0], xs[15:8], 1'b0, 1'b1, 1'b1);
      issue(1'b1, xs[7:0], xs[15:8], xs[16], xs[17], xs[20:18] == 3'd0);
    end
    drain();

    // Asynchronous reset with two ops in flight
    issue(1'b1, 8'd12, 8'd10, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 8'd3, 8'd3, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    issue(1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b1);
    drain();
    check_eq("post_reset_y", 64'(y0), 64'd81);
    check_eq("post_reset_acc", 64'(acc0), 64'd81);

    for (int k = 0; k < 3; k++)
      check_eq($sformatf("d%0d_pulse_count", k), 64'(n_out[k]), 64'(n_iss[k]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_pipe_mac.md
Name: multiplier_pipe_mac

Overview:
Parametrised pipelined multiplier with a configurable pipeline depth, per-operation signed/unsigned mode and valid tagging. It includes an optional multiply-accumulate back end with clear and sticky overflow.
It is the next generation of the team's behavioural pipelined multiplier, and serves as the arithmetic core for filter and dot-product datapaths.
There is no backpressure: one operation may be issued every cycle.

Parameters:
- WIDTH, 8: operand width in bits (>=2).
- STAGES, 3: product latency in clock edges (>=1); the implementation may distribute partial-product logic across stages freely.
- ACC_WIDTH, 2*WIDTH+8: accumulator width (>=2*WIDTH).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operands valid this cycle.
- a, input, WIDTH: multiplicand.
- b, input, WIDTH: multiplier.
- signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned.
- acc_en, input, 1: add this product into the accumulator.
- acc_clr, input, 1: this operation starts a new accumulation.
- out_valid, output, 1: y holds a new product this cycle.
- y, output, 2*WIDTH: full-width product.
- acc_valid, output, 1: acc updated this cycle.
- acc, output, ACC_WIDTH: accumulator value.
- acc_ovf, output, 1: sticky accumulator wrap flag.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all pipeline valid bits 0; out_valid=0, y=0, acc_valid=0, acc=0, acc_ovf=0.
- Reset mid-operation: every in-flight operation is discarded and none ever produces out_valid or acc_valid.
- Issue: on each rising edge, {in_valid, a, b, signed_mode, acc_en, acc_clr} is sampled. The control tags travel with their operands through every stage.
- Product latency:
  - An operation sampled at edge E drives y and out_valid=1 after edge E+STAGES-1.
  - STAGES=1 gives a result visible one cycle after presentation.
  - out_valid is high for exactly one cycle per valid operation.
  - Back-to-back issues give back-to-back out_valid.
- Bubbles: data registers load only for valid operations. y holds the last product while out_valid=0.
- Arithmetic:
  - signed_mode=0: y = a*b, unsigned, exact in 2*WIDTH bits.
  - signed_mode=1: y = a*b, two's complement, exact in 2*WIDTH bits. Example: -128*-128 = 0x4000 for WIDTH=8.
  - Mode may change on every operation; each operation uses its own tag.
- Accumulator: updated on the edge after that operation's out_valid cycle, so acc latency is STAGES+1. p is y extended to ACC_WIDTH (sign-extended if the op was signed, zero-extended otherwise).
  - acc_en=1, acc_clr=0: acc <= acc+p; acc_valid=1.
  - acc_en=1, acc_clr=1: acc <= p; acc_ovf <= 0; acc_valid=1.
  - acc_en=0, acc_clr=1: acc <= 0; acc_ovf <= 0; acc_valid=1.
  - acc_en=0, acc_clr=0: acc unchanged; acc_valid=0.
  - Invalid slots never touch acc.
- Overflow:
  - Addition wraps modulo 2^ACC_WIDTH.
  - Unsigned op: acc_ovf is set on a carry out of the MSB.
  - Signed op: acc_ovf is set when the operand signs are equal and the result sign differs.
  - acc_ovf is sticky until a clr operation or reset. A clr operation's own add cannot set it.
- Simultaneous events: reset dominates everything. acc_clr dominates the accumulated history, never the current product.
- No combinational path from inputs to outputs: all outputs are registered.

Test Plan:
- Latency, WIDTH=8, STAGES=3: single unsigned op a=12, b=10 -> out_valid pulses once after edge E+2 with y=120. Repeat with STAGES=1: y=120 after edge E.
- Mode toggle, back-to-back: a=0xFF, b=0xFF signed, then the same operands unsigned on the next cycle -> y=0x0001 then y=0xFE01 on consecutive out_valid cycles. Also signed 0x80*0x80 -> 0x4000.
- Random stream: 20 xorshift operand pairs with random in_valid gaps and random mode -> every y matches the reference model delayed by STAGES. y holds its value during gaps. Count of out_valid pulses equals count of issues.
- Accumulate, default ACC_WIDTH:
  - 3*4 with acc_clr=1, acc_en=1, then 5*6 and 7*8 with acc_en=1 -> acc = 12, 42, 98 on successive acc_valid cycles; acc_ovf=0.
  - Signed -2*3 with acc_en=1 -> acc = 92.
- Overflow, ACC_WIDTH=16: unsigned 255*255 with clr, then 255*255 with acc_en -> acc=0xFE01, then acc=0xFC02 with acc_ovf=1. A following clr op 1*1 -> acc=1, acc_ovf=0.
- Reset mid-stream: assert rst asynchronously, between edges, with 2 ops in flight -> all outputs are 0 immediately, and no out_valid or acc_valid appears for the discarded ops. The first op issued after release completes normally.
